// File: rtl/bshift_pkg.sv
// bshift_pkg -- shared types and size helpers for the pipelined barrel shifter.
//   shift_mode_t : operation selector carried with each beat
//   shw_of()     : number of mux stages (= amount width) for a data width
//   ranks_of()   : number of register ranks (= latency in cycles)
package bshift_pkg;

  typedef enum logic [1:0] {
    ROR = 2'b00,
    ROL = 2'b01,
    SRL = 2'b10,
    SRA = 2'b11
  } shift_mode_t;

  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

  function automatic int ranks_of(input int width, input int reg_every);
    return (shw_of(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/bshift_stage.sv
// bshift_stage -- one combinational mux stage of the barrel shifter.
// Applies a fixed 2^K shift/rotate when en is set, otherwise passes src through.
//   src       : operand entering this stage
//   mode      : ROR / ROL / SRL / SRA
//   en        : amount bit K of the beat
//   res       : operand leaving this stage
//   carry_src : carry entering this stage   (BSHIFT_CARRY_EN only)
//   carry_res : carry leaving this stage    (BSHIFT_CARRY_EN only)
// Optional feature macro: BSHIFT_CARRY_EN.
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic [WIDTH-1:0] src,
  input  shift_mode_t      mode,
  input  logic             en,
`ifdef BSHIFT_CARRY_EN
  input  logic             carry_src,
  output logic             carry_res,
`endif
  output logic [WIDTH-1:0] res
);

  localparam int S = 1 << K;

  logic [WIDTH-1:0] rot_r, rot_l, shr;
  logic [S-1:0]     fill;

  assign rot_r = {src[S-1:0], src[WIDTH-1:S]};
  assign rot_l = {src[WIDTH-S-1:0], src[WIDTH-1:WIDTH-S]};
  assign fill  = (mode == SRA) ? {S{src[WIDTH-1]}} : '0;
  assign shr   = {fill, src[WIDTH-1:S]};

  always_comb begin
    res = src;
    if (en) begin
      unique case (mode)
        ROR:     res = rot_r;
        ROL:     res = rot_l;
        default: res = shr;
      endcase
    end
  end

`ifdef BSHIFT_CARRY_EN
  // The last active stage decides the carry. For right shifts and ROR the bit
  // that leaves (and for ROR lands in the MSB) is src[S-1]; after the earlier,
  // smaller shifts that is original bit n-1. For ROL the bit landing in the
  // LSB is src[W-S].
  always_comb begin
    carry_res = carry_src;
    if (en) carry_res = (mode == ROL) ? src[WIDTH-S] : src[S-1];
  end
`endif

endmodule

// File: rtl/bshifter_pipe.sv
// bshifter_pipe -- parametrised, elastic, pipelined barrel shifter.
// log2(WIDTH) mux stages, a register rank after every REG_EVERY stages and
// after the last; amount and mode travel with the data.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data, in_amt, in_mode sampled on accept
//   out_valid/out_ready : output handshake; out_data (and out_carry) held while stalled
//   out_carry           : last bit shifted out (BSHIFT_CARRY_EN only)
// Latency RANKS cycles: a beat accepted at edge e is visible after edge e+RANKS-1.
// Optional feature macro: BSHIFT_CARRY_EN.
module bshifter_pipe
  import bshift_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
`ifdef BSHIFT_CARRY_EN
  ,
  output logic                     out_carry
`endif
);

  localparam int SHW   = shw_of(WIDTH);
  localparam int RANKS = ranks_of(WIDTH, REG_EVERY);

  // rank registers
  logic [RANKS-1:0]            vld_pipe;
  logic [RANKS-1:0][WIDTH-1:0] rank_data;
  logic [RANKS-1:0][SHW-1:0]   rank_amt;
  logic [RANKS-1:0][1:0]       rank_mode;

  // what each rank's stage group consumes (input port or previous rank)
  logic [RANKS-1:0]            head_valid;
  logic [RANKS-1:0][WIDTH-1:0] head_data;
  logic [RANKS-1:0][SHW-1:0]   head_amt;
  logic [RANKS-1:0][1:0]       head_mode;
  logic [RANKS-1:0][WIDTH-1:0] next_data;

  logic [SHW-1:0][WIDTH-1:0]   st_src, st_res;

  logic [RANKS-1:0]            load;
  logic                        tail_full;

`ifdef BSHIFT_CARRY_EN
  logic [RANKS-1:0]            rank_carry, head_carry, next_carry;
  logic [SHW-1:0]              st_carry_src, st_carry_res;
`endif

  for (genvar r = 0; r < RANKS; r++) begin : g_rank
    localparam int LAST = ((r + 1) * REG_EVERY < SHW) ? (r + 1) * REG_EVERY - 1 : SHW - 1;
    if (r == 0) begin : g_first
      assign head_valid[r] = in_valid;
      assign head_data[r]  = in_data;
      assign head_amt[r]   = in_amt;
      assign head_mode[r]  = in_mode;
`ifdef BSHIFT_CARRY_EN
      assign head_carry[r] = 1'b0;
`endif
    end else begin : g_next
      assign head_valid[r] = vld_pipe[r-1];
      assign head_data[r]  = rank_data[r-1];
      assign head_amt[r]   = rank_amt[r-1];
      assign head_mode[r]  = rank_mode[r-1];
`ifdef BSHIFT_CARRY_EN
      assign head_carry[r] = rank_carry[r-1];
`endif
    end
    assign next_data[r] = st_res[LAST];
`ifdef BSHIFT_CARRY_EN
    assign next_carry[r] = st_carry_res[LAST];
`endif
  end

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int R = k / REG_EVERY;
    if (k % REG_EVERY == 0) begin : g_head
      assign st_src[k] = head_data[R];
`ifdef BSHIFT_CARRY_EN
      assign st_carry_src[k] = head_carry[R];
`endif
    end else begin : g_chain
      assign st_src[k] = st_res[k-1];
`ifdef BSHIFT_CARRY_EN
      assign st_carry_src[k] = st_carry_res[k-1];
`endif
    end

    bshift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .src       (st_src[k]),
      .mode      (shift_mode_t'(head_mode[R])),
      .en        (head_amt[R][k]),
`ifdef BSHIFT_CARRY_EN
      .carry_src (st_carry_src[k]),
      .carry_res (st_carry_res[k]),
`endif
      .res       (st_res[k])
    );
  end

  // Rank r may load when it or any rank downstream of it has a hole, or when
  // the consumer takes the head beat. Written as a suffix-AND rather than a
  // ready chain so no bit of load depends on another.
  always_comb begin
    load      = '0;
    tail_full = 1'b1;
    for (int r = RANKS - 1; r >= 0; r--) begin
      tail_full = tail_full & vld_pipe[r];
      load[r]   = out_ready | ~tail_full;
    end
  end

  assign in_ready = load[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      rank_data  <= '0;
      rank_amt   <= '0;
      rank_mode  <= '0;
`ifdef BSHIFT_CARRY_EN
      rank_carry <= '0;
`endif
    end else begin
      for (int r = 0; r < RANKS; r++) begin
        if (load[r]) begin
          vld_pipe[r]   <= head_valid[r];
          rank_data[r]  <= next_data[r];
          rank_amt[r]   <= head_amt[r];
          rank_mode[r]  <= head_mode[r];
`ifdef BSHIFT_CARRY_EN
          rank_carry[r] <= next_carry[r];
`endif
        end
      end
    end
  end

  assign out_valid = vld_pipe[RANKS-1];
  assign out_data  = rank_data[RANKS-1];
`ifdef BSHIFT_CARRY_EN
  assign out_carry = rank_carry[RANKS-1];
`endif

  // amount/mode of the final rank have no further stage to steer
  logic unused_tail;
  assign unused_tail = ^{rank_amt[RANKS-1], rank_mode[RANKS-1]};

endmodule

// File: tb/tb_bshifter_pipe.sv
`timescale 1ns/1ps
module tb_bshifter_pipe;

  localparam int W     = 16;
  localparam int RE    = 1;
  localparam int SHW   = $clog2(W);
  localparam int RANKS = (SHW + RE - 1) / RE;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [SHW-1:0] in_amt = '0;
  logic [1:0]     in_mode = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
`ifdef BSHIFT_CARRY_EN
  logic           out_carry;
`endif

  always #5 clk = ~clk;

  bshifter_pipe #(.WIDTH(W), .REG_EVERY(RE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BSHIFT_CARRY_EN
    ,
    .out_carry (out_carry)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (bit-by-bit from the shift rules) ----------------
  typedef struct packed { logic [W-1:0] d; logic c; } res_t;

  function automatic res_t model(input logic [1:0] m, input logic [W-1:0] a, input int n);
    res_t r;
    r.d = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'b00:   r.d[i] = a[(i + n) % W];
        2'b01:   r.d[i] = a[(i - n + W) % W];
        2'b10:   r.d[i] = (i + n < W) ? a[(i + n) % W] : 1'b0;
        default: r.d[i] = (i + n < W) ? a[(i + n) % W] : a[W-1];
      endcase
    end
    if (n == 0)         r.c = 1'b0;
    else if (m == 2'b00) r.c = r.d[W-1];
    else if (m == 2'b01) r.c = r.d[0];
    else                 r.c = a[n-1];
    return r;
  endfunction

  // ---------------- scoreboard / monitor (samples on negedge) ----------------
  res_t         exp_q[$];
  int           pop_log[$];
  int           cyc = 0;
  logic         held_v = 1'b0;
  logic [W-1:0] held_d;
  logic         held_c;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_hold_data", 32'(out_data), 32'(held_d));
`ifdef BSHIFT_CARRY_EN
        chk("stall_hold_carry", 32'(out_carry), 32'(held_c));
`endif
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, want no output", out_data);
        end else begin
          r = exp_q.pop_front();
          if (out_data !== r.d) begin
            n_err++;
            $display("FAIL sb_data: got 0x%0h, want 0x%0h", out_data, r.d);
          end
`ifdef BSHIFT_CARRY_EN
          chk("sb_carry", 32'(out_carry), 32'(r.c));
`endif
          pop_log.push_back(cyc);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
`ifdef BSHIFT_CARRY_EN
      held_c = out_carry;
`else
      held_c = 1'b0;
`endif
      if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_data, int'(in_amt)));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] a;
    int           n;
    logic [W-1:0] d;
    logic         c;
  } vec_t;

  vec_t vt[14];

  // All tasks enter and leave at posedge+1.
  task automatic send_one(input vec_t v, input int idx);
    in_valid = 1'b1;
    in_mode  = v.m;
    in_data  = v.a;
    in_amt   = SHW'(v.n);
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < RANKS - 1; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_early_valid", idx), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk($sformatf("vec%0d_valid", idx), 32'(out_valid), 32'd1);
    chk($sformatf("vec%0d_data", idx), 32'(out_data), 32'(v.d));
`ifdef BSHIFT_CARRY_EN
    chk($sformatf("vec%0d_carry", idx), 32'(out_carry), 32'(v.c));
`endif
    @(posedge clk); #1;
  endtask

  task automatic stream(input int nbeats, input int max_cyc, output int acc, output int used);
    acc  = 0;
    used = 0;
    while (used < max_cyc && acc < nbeats) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      in_amt   = SHW'($urandom_range(W - 1, 0));
      in_mode  = 2'($urandom_range(3, 0));
      @(negedge clk);
      if (in_ready) acc++;
      used++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string nm, input int bound);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      @(posedge clk); #1;
      c++;
    end
    chk({nm, "_drained_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, used;
    vt[0]  = '{2'b00, 16'h8001, 1,  16'hC000, 1'b1};
    vt[1]  = '{2'b01, 16'h8001, 4,  16'h0018, 1'b0};
    vt[2]  = '{2'b11, 16'h8000, 15, 16'hFFFF, 1'b0};
    vt[3]  = '{2'b10, 16'h8000, 15, 16'h0001, 1'b0};
    vt[4]  = '{2'b00, 16'hA5C3, 0,  16'hA5C3, 1'b0};
    vt[5]  = '{2'b01, 16'hA5C3, 0,  16'hA5C3, 1'b0};
    vt[6]  = '{2'b10, 16'hA5C3, 0,  16'hA5C3, 1'b0};
    vt[7]  = '{2'b11, 16'hA5C3, 0,  16'hA5C3, 1'b0};
    vt[8]  = '{2'b10, 16'h0003, 1,  16'h0001, 1'b1};
    vt[9]  = '{2'b00, 16'h0001, 1,  16'h8000, 1'b1};
    vt[10] = '{2'b11, 16'h9000, 3,  16'hF200, 1'b0};
    vt[11] = '{2'b01, 16'h1234, 8,  16'h3412, 1'b0};
    vt[12] = '{2'b00, 16'h1234, 4,  16'h4123, 1'b0};
    vt[13] = '{2'b10, 16'hFFFF, 15, 16'h0001, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // directed vectors with latency check
    foreach (vt[i]) send_one(vt[i], i);
    wait_empty("vec", 10);

    // back-to-back random stream
    pop_log.delete();
    stream(20, 40, acc, used);
    chk("stream_accepts", 32'(acc), 32'd20);
    chk("stream_no_bubble", 32'(used), 32'd20);
    wait_empty("stream", 20);
    chk("stream_outputs", 32'(pop_log.size()), 32'd20);
    if (pop_log.size() == 20)
      chk("stream_back_to_back", 32'(pop_log[19] - pop_log[0]), 32'd19);

    // stall: consumer blocks for 10 cycles while the producer keeps offering
    pop_log.delete();
    out_ready = 1'b0;
    stream(100, 10, acc, used);
    chk("stall_accepts", 32'(acc), 32'(RANKS));
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    // full pipe, consumer releases, new beat offered: accepted the same cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'($urandom);
    in_amt    = SHW'($urandom_range(W - 1, 0));
    in_mode   = 2'($urandom_range(3, 0));
    @(negedge clk);
    chk("full_pass_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_empty("stall", 20);
    chk("stall_outputs", 32'(pop_log.size()), 32'(RANKS + 1));

    // mixed random ready/valid
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      in_data   = W'($urandom);
      in_amt    = SHW'($urandom_range(W - 1, 0));
      in_mode   = 2'($urandom_range(3, 0));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty("random", 20);

    // reset with beats in flight
    out_ready = 1'b0;
    stream(3, 10, acc, used);
    chk("flush_accepts", 32'(acc), 32'd3);
    @(posedge clk); #1;
    chk("flush_pre_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_flush_valid", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
